// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory with fixed access latency for the multi-cycle CPU MEM state.
// One request in flight at a time; completion is signalled by a one-cycle ready pulse.
module data_mem_responder #(
   parameter int unsigned DEPTH_BYTES = 128,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        Rst,
   input  logic        req,
   input  logic        we,
   input  logic        half,
   input  logic        sg,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH_BYTES);
   localparam int unsigned CW = $clog2(LATENCY) + 1;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            accept, done, misal;
   logic            we_q, half_q, sg_q;
   logic [AW-1:0]   addr_q, a1, a2, a3;
   logic [31:0]     wdata_q, word_rd, load_val;
   logic [15:0]     hw_rd;
   logic [7:0]      mem [DEPTH_BYTES];
   logic            addr_hi_unused;

   // Address bits above the memory size are deliberately dropped so accesses wrap.
   assign addr_hi_unused = ^addr[31:AW];

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               accept  = 1'b1;
               cnt_n   = CW'(LATENCY - 1);
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               done    = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      misal   = half_q ? addr_q[0] : (addr_q[1:0] != 2'b00);
      a1      = addr_q + AW'(1);
      a2      = addr_q + AW'(2);
      a3      = addr_q + AW'(3);
      word_rd = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
      hw_rd   = {mem[addr_q], mem[a1]};
      if (half_q) begin
         load_val = sg_q ? {{16{hw_rd[15]}}, hw_rd} : {16'h0000, hw_rd};
      end else begin
         load_val = word_rd;
      end
   end

   always_ff @(posedge CLK or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge CLK or negedge Rst) begin
      if (!Rst) begin
         we_q    <= 1'b0;
         half_q  <= 1'b0;
         sg_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= we;
         half_q  <= half;
         sg_q    <= sg;
         addr_q  <= addr[AW-1:0];
         wdata_q <= wdata;
      end
   end

   always_ff @(posedge CLK or negedge Rst) begin
      if (!Rst) begin
         rdata <= '0;
         ready <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         ready <= done;
         err   <= done & misal;
         busy  <= (state_n == WAIT);
         if (done) begin
            if (misal) begin
               rdata <= '0;
            end else if (!we_q) begin
               rdata <= load_val;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge Rst) begin
      if (!Rst) begin
         for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
            mem[i] <= '0;
         end
      end else if (done && we_q && !misal) begin
         mem[addr_q] <= half_q ? wdata_q[15:8] : wdata_q[31:24];
         mem[a1]     <= half_q ? wdata_q[7:0]  : wdata_q[23:16];
         if (!half_q) begin
            mem[a2] <= wdata_q[15:8];
            mem[a3] <= wdata_q[7:0];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder with the default 128-byte, latency-2 configuration.
module tb_data_mem_responder;

   logic        CLK = 1'b0;
   logic        Rst;
   logic        req, we, half, sg;
   logic [31:0] addr, wdata, rdata;
   logic        ready, busy, err;

   int tests = 0;
   int fails = 0;

   data_mem_responder #(.DEPTH_BYTES(128), .LATENCY(2)) dut (
      .CLK   (CLK),
      .Rst   (Rst),
      .req   (req),
      .we    (we),
      .half  (half),
      .sg    (sg),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ready (ready),
      .busy  (busy),
      .err   (err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete access: accept, wait (bounded) for ready, then check the pulse ends.
   task automatic op(input string tag, input logic w, input logic h, input logic s,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err);
      int lat;
      @(negedge CLK);
      req = 1'b1; we = w; half = h; sg = s; addr = a; wdata = d;
      @(posedge CLK); #1;
      req = 1'b0;
      chk({tag, ".busy_on"}, 32'(busy), 32'd1);
      lat = 0;
      while (ready !== 1'b1 && lat < 10) begin
         @(posedge CLK); #1;
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'd2);
      chk({tag, ".busy_off"}, 32'(busy), 32'd0);
      chk({tag, ".rdata"}, rdata, exp_rd);
      chk({tag, ".err"}, 32'(err), 32'(exp_err));
      @(posedge CLK); #1;
      chk({tag, ".ready_drop"}, 32'(ready), 32'd0);
      chk({tag, ".err_drop"}, 32'(err), 32'd0);
   endtask

   initial begin
      logic [9:0]  rmask;
      logic [31:0] rd5, rd8;
      int          lat;

      Rst = 1'b0; req = 1'b0; we = 1'b0; half = 1'b0; sg = 1'b0;
      addr = '0; wdata = '0;
      #12;
      chk("rst.rdata", rdata, 32'h0);
      chk("rst.ready", 32'(ready), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      @(negedge CLK);
      Rst = 1'b1;

      op("st4", 1'b1, 1'b0, 1'b0, 32'd4, 32'h11223344, 32'h0, 1'b0);
      op("ld4", 1'b0, 1'b0, 1'b0, 32'd4, 32'h0, 32'h11223344, 1'b0);
      op("ldh6", 1'b0, 1'b1, 1'b0, 32'd6, 32'h0, 32'h00003344, 1'b0);

      // Reset in the WAIT state of a store; outputs must clear before the next edge.
      @(negedge CLK);
      req = 1'b1; we = 1'b1; half = 1'b0; addr = 32'd8; wdata = 32'hDEADBEEF;
      @(posedge CLK); #1;
      req = 1'b0;
      chk("midrst.busy_on", 32'(busy), 32'd1);
      #2 Rst = 1'b0;
      #1;
      chk("midrst.rdata", rdata, 32'h0);
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.ready", 32'(ready), 32'd0);
      chk("midrst.err", 32'(err), 32'd0);
      @(negedge CLK);
      Rst = 1'b1;
      op("midrst.ld8", 1'b0, 1'b0, 1'b0, 32'd8, 32'h0, 32'h0, 1'b0);
      op("midrst.ld4", 1'b0, 1'b0, 1'b0, 32'd4, 32'h0, 32'h0, 1'b0);

      op("st4b", 1'b1, 1'b0, 1'b0, 32'd4, 32'h11223344, 32'h0, 1'b0);
      op("sth10", 1'b1, 1'b1, 1'b0, 32'd10, 32'h55558001, 32'h0, 1'b0);
      op("ldh10s", 1'b0, 1'b1, 1'b1, 32'd10, 32'h0, 32'hFFFF8001, 1'b0);
      op("ldh10u", 1'b0, 1'b1, 1'b0, 32'd10, 32'h0, 32'h00008001, 1'b0);
      op("ld12", 1'b0, 1'b0, 1'b0, 32'd12, 32'h0, 32'h0, 1'b0);
      op("ld8", 1'b0, 1'b0, 1'b0, 32'd8, 32'h0, 32'h00008001, 1'b0);

      op("mis.st6", 1'b1, 1'b0, 1'b0, 32'd6, 32'hCAFEF00D, 32'h0, 1'b1);
      op("mis.ld4", 1'b0, 1'b0, 1'b0, 32'd4, 32'h0, 32'h11223344, 1'b0);
      op("mis.ldh3", 1'b0, 1'b1, 1'b1, 32'd3, 32'h0, 32'h0, 1'b1);

      // Back-to-back with req held: wrapped store, load of the same word, then load of 4.
      rmask = '0; rd5 = '0; rd8 = '0;
      @(negedge CLK);
      req = 1'b1; we = 1'b1; half = 1'b0; sg = 1'b0; addr = 32'd140; wdata = 32'h0BADF00D;
      @(posedge CLK); #1;
      rmask[0] = ready;
      @(negedge CLK);
      we = 1'b0; addr = 32'd12;
      for (int k = 1; k <= 9; k++) begin
         @(posedge CLK); #1;
         rmask[k] = ready;
         if (k == 5) rd5 = rdata;
         if (k == 8) rd8 = rdata;
         @(negedge CLK);
         if (k == 3) addr = 32'd4;
         if (k == 6) req = 1'b0;
      end
      chk("b2b.ready_mask", 32'(rmask), 32'h124);
      chk("b2b.wrap_ld12", rd5, 32'h0BADF00D);
      chk("b2b.ld4", rd8, 32'h11223344);

      // Inputs wiggled during WAIT must not disturb the latched store.
      @(negedge CLK);
      req = 1'b1; we = 1'b1; half = 1'b0; addr = 32'd16; wdata = 32'h12345678;
      @(posedge CLK); #1;
      req = 1'b0; we = 1'b0; half = 1'b1; addr = 32'd20; wdata = 32'hFFFFFFFF;
      lat = 0;
      while (ready !== 1'b1 && lat < 10) begin
         @(negedge CLK);
         addr = addr + 32'd4; we = ~we; req = 1'b1;
         @(posedge CLK); #1;
         lat++;
      end
      req = 1'b0;
      chk("ign.latency", 32'(lat), 32'd2);
      chk("ign.err", 32'(err), 32'd0);
      chk("ign.rdata_hold", rdata, 32'h11223344);
      op("ign.ld16", 1'b0, 1'b0, 1'b0, 32'd16, 32'h0, 32'h12345678, 1'b0);
      op("ign.ld20", 1'b0, 1'b0, 1'b0, 32'd20, 32'h0, 32'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
